seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised iterative shift-add multiplier, successor to the single-cycle 8-bit array multiplier. Operand width is generic, signed/unsigned mode is selected per operation, and both input and output use valid/ready handshakes. One partial product is retired per cycle, trading latency for area. It sits behind any producer/consumer pair using the team's valid/ready convention.

## Interface
- `Width`, default 8, operand width in bits; legal range ≥ 2; product width is `2*Width`.

- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_i`  in  1  reset; synchronous, active-high
- `data_in1_i`  in  Width  multiplicand
- `data_in2_i`  in  Width  multiplier
- `signed_i`  in  1  1: operands and product are two's complement; 0: unsigned; sampled with the operands
- `in_valid_i`  in  1  operands/mode valid
- `in_ready_o`  out  1  block can accept an operation
- `data_out_o`  out  2*Width  product
- `data_out_valid_o`  out  1  product valid
- `out_ready_i`  in  1  consumer accepts the product

## Operation
- FSM states: IDLE, BUSY, DONE.
- `in_ready_o` = 1 exactly when state is IDLE; combinational from state only.
- Input handshake: `in_valid_i && in_ready_o` at a rising edge.
  - Registers |a|, |b| as `Width`-bit unsigned magnitudes; magnitude equals the raw value when `signed_i`=0.
  - Registers negate flag = `signed_i & (a[MSB] ^ b[MSB])`.
  - Clears the 2*Width-bit accumulator, loads iteration counter = `Width`, goes to BUSY.
- BUSY, each cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper `Width+1` bits of the accumulator.
  - Shift accumulator and multiplier right by 1; decrement counter.
- On the edge completing the final iteration:
  - `data_out_o` is loaded with the accumulator result, two's-complement negated if the negate flag is set.
  - `data_out_valid_o` is set and state goes to DONE.
- DONE: `data_out_o` and `data_out_valid_o` hold stable until `out_ready_i`=1. On that edge `data_out_valid_o` clears and state goes to IDLE.
- `data_out_o` retains its last value while invalid.
- Inputs are ignored when `in_ready_o`=0.
- Arithmetic:
  - Product is exact in 2*Width bits for both modes; no overflow, no saturation.
  - Signed corner case: -2^(W-1) × -2^(W-1) = 2^(2W-2). Its magnitude 2^(W-1) fits in `Width` unsigned bits.
- One operation in flight at a time; no pipelining across operations.

## Timing
- Reset values (after any edge with `rst_i`=1): state IDLE, `in_ready_o`=1, `data_out_valid_o`=0, `data_out_o`=0, accumulator/counter 0.
- Reset mid-operation: the operation is abandoned and no result is produced. Reset overrides any simultaneous input or output handshake.
- Latency: input handshake at edge E0 → `data_out_valid_o`=1 after edge E_Width, i.e. exactly `Width` cycles later.
- With `out_ready_i` tied high:
  - Output handshake at E_(Width+1).
  - `in_ready_o`=1 again after that edge, so the next accept is possible at E_(Width+2).
  - Throughput: one operation per `Width`+2 cycles.
- No combinational path from `in_valid_i` or `out_ready_i` to any output.
- `Width` < 2 triggers an elaboration-time error.

## Test plan
- **Unsigned maximum, Width=8:** 0xFF × 0xFF, `signed_i`=0 → `data_out_o`=0xFE01, `data_out_valid_o` rises exactly 8 cycles after accept, `in_ready_o`=0 throughout BUSY/DONE.
- **Signed corners, Width=8:**
  - -128 × -128 → 0x4000
  - -128 × 127 → 0xC080
  - 0xFF × 0x01 signed → 0xFFFF
  - 0xFF × 0x01 unsigned → 0x00FF
  - 0 × 0x80 → 0x0000
- **Backpressure:** hold `out_ready_i`=0 for 5 cycles in DONE with `in_valid_i`=1 and new operands → `data_out_o`/`data_out_valid_o` unchanged and no new operation accepted. The first result is delivered when ready rises, then the block returns to IDLE.
- **Reset mid-BUSY:** assert `rst_i` after 3 iterations of 0x12 × 0x34 → next cycle `in_ready_o`=1, `data_out_valid_o`=0, `data_out_o`=0. A following 3 × 5 completes as 0x000F, 8 cycles after accept.
- **Streaming:** `out_ready_i`=1, `in_valid_i`=1 continuously → accept every 10 cycles, results in order.
- **Randomised check:** 1000 random operands and modes checked against a reference model, at Width=8 and Width=16. Random `out_ready_i` stalls must not alter any result.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, signed or unsigned
// per operation, valid/ready on both the operand and the product side.
module seq_multiplier #(
    parameter int Width = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [Width-1:0]     data_in1_i,
    input  logic [Width-1:0]     data_in2_i,
    input  logic                 signed_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [2*Width-1:0]   data_out_o,
    output logic                 data_out_valid_o,
    input  logic                 out_ready_i,
    output logic [1:0]           state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // ready never depends on valid, and valid/data hold stable until accepted.

    if (Width < 2) begin : g_width_check
        $error("seq_multiplier: Width must be >= 2");
    end

    localparam int CntW = $clog2(Width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [Width-1:0]       mcand_q, mcand_d;
    logic [Width-1:0]       mplier_q, mplier_d;
    logic                   neg_q, neg_d;
    logic [2*Width-1:0]     acc_q, acc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*Width-1:0]     out_q, out_d;
    logic                   valid_q, valid_d;

    logic [Width-1:0]       mag1, mag2;
    logic [Width:0]         partial;
    logic [2*Width-1:0]     acc_step;
    logic [2*Width-1:0]     result;

    // Magnitudes are Width-bit unsigned, so -2^(Width-1) maps onto itself correctly.
    assign mag1 = (signed_i && data_in1_i[Width-1]) ? -data_in1_i : data_in1_i;
    assign mag2 = (signed_i && data_in2_i[Width-1]) ? -data_in2_i : data_in2_i;

    // Add into the upper Width+1 bits, then shift the whole accumulator right by one.
    assign partial  = {1'b0, acc_q[2*Width-1:Width]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {partial, acc_q[Width-1:1]};
    assign result   = neg_q ? -acc_step : acc_step;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    neg_d    = signed_i & (data_in1_i[Width-1] ^ data_in2_i[Width-1]);
                    acc_d    = '0;
                    cnt_d    = CntW'(Width);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    out_d   = result;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

    assign in_ready_o       = (state_q == IDLE);
    assign data_out_o       = out_q;
    assign data_out_valid_o = valid_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed vector table, multi-cycle corner sequences,
// and randomised operations at Width=8 and Width=16 against an arithmetic model.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        s8 = 1'b0, iv8 = 1'b0, ir8, dv8, or8 = 1'b0;
    logic [15:0] do8;
    logic [1:0]  st8;

    logic [15:0] a16 = '0, b16 = '0;
    logic        s16 = 1'b0, iv16 = 1'b0, ir16, dv16, or16 = 1'b0;
    logic [31:0] do16;
    logic [1:0]  st16;

    seq_multiplier #(.Width(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .data_in1_i(a8), .data_in2_i(b8), .signed_i(s8),
        .in_valid_i(iv8), .in_ready_o(ir8), .data_out_o(do8), .data_out_valid_o(dv8),
        .out_ready_i(or8), .state_o(st8)
    );

    seq_multiplier #(.Width(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .data_in1_i(a16), .data_in2_i(b16), .signed_i(s16),
        .in_valid_i(iv16), .in_ready_o(ir16), .data_out_o(do16), .data_out_valid_o(dv16),
        .out_ready_i(or16), .state_o(st16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as interpreted by the mode.
    function automatic logic [31:0] ref_mul(input bit w16, input logic [15:0] a, input logic [15:0] b,
                                            input bit s);
        longint x, y, p;
        logic [7:0] a_lo, b_lo;
        a_lo = a[7:0];
        b_lo = b[7:0];
        if (w16) begin
            x = s ? longint'($signed(a)) : longint'(a);
            y = s ? longint'($signed(b)) : longint'(b);
        end else begin
            x = s ? longint'($signed(a_lo)) : longint'(a_lo);
            y = s ? longint'($signed(b_lo)) : longint'(b_lo);
        end
        p = x * y;
        return w16 ? p[31:0] : {16'h0, p[15:0]};
    endfunction

    function automatic bit rdy(input bit w16);
        return w16 ? ir16 : ir8;
    endfunction
    function automatic bit vld(input bit w16);
        return w16 ? dv16 : dv8;
    endfunction
    function automatic logic [31:0] dout(input bit w16);
        return w16 ? do16 : {16'h0, do8};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_out_ready(input bit w16, input bit v);
        if (w16) or16 = v; else or8 = v;
    endtask

    // Full operation: accept, wait for the product, hold it for `stall` cycles, then consume.
    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b, input bit s,
                          input int stall, output logic [31:0] prod, output int lat);
        int k;
        bit busy_ok, hold_ok;
        k = 0;
        prod = '0;
        lat = 0;
        while (!rdy(w16) && k < 50) begin
            tick();
            k++;
        end
        if (!rdy(w16)) begin
            check("ready_timeout", 32'(rdy(w16)), 32'd1);
            return;
        end
        if (w16) begin
            a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; s8 = s; iv8 = 1'b1;
        end
        tick();
        iv16 = 1'b0;
        iv8  = 1'b0;
        busy_ok = 1'b1;
        while (!vld(w16) && lat < 40) begin
            if (rdy(w16)) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check("busy_in_ready_low", 32'(busy_ok), 32'd1);
        if (!vld(w16)) begin
            check("valid_timeout", 32'(vld(w16)), 32'd1);
            return;
        end
        prod = dout(w16);
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!vld(w16) || dout(w16) !== prod || rdy(w16)) hold_ok = 1'b0;
        end
        if (stall > 0) check("stall_hold", 32'(hold_ok), 32'd1);
        set_out_ready(w16, 1'b1);
        tick();
        set_out_ready(w16, 1'b0);
        check("exit_valid_ready", {30'b0, vld(w16), rdy(w16)}, 32'd1);
    endtask

    function automatic logic [15:0] pick_operand(input bit w16);
        int sel;
        logic [15:0] v;
        sel = $urandom_range(0, 9);
        v = 16'($urandom);
        case (sel)
            0: v = '0;
            1: v = w16 ? 16'hFFFF : 16'h00FF;
            2: v = w16 ? 16'h8000 : 16'h0080;
            3: v = w16 ? 16'h7FFF : 16'h007F;
            default: ;
        endcase
        return v;
    endfunction

    initial begin : main
        vec_t vecs[11];
        logic [31:0] prod, e;
        int lat;
        int acc_cyc[$];
        int n_res;
        bit acc_now;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[4]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vecs[5]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
        vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[7]  = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
        vecs[8]  = '{8'h0C, 8'h0D, 1'b0, 16'h009C};
        vecs[9]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[10] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready8", 32'(ir8), 32'd1);
        check("rst_valid8", 32'(dv8), 32'd0);
        check("rst_dout8", {16'h0, do8}, 32'd0);
        check("rst_in_ready16", 32'(ir16), 32'd1);
        check("rst_dout16", do16, 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(1'b0, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, vecs[i].s, 0, prod, lat);
            check($sformatf("vec%0d_product", i), prod, {16'h0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
        end

        // Backpressure: new operands offered while the product waits
        a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        for (int k = 0; k < 40 && !dv8; k++) tick();
        check("bp_first_valid", 32'(dv8), 32'd1);
        a8 = 8'h03; b8 = 8'h05; iv8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_data", {16'h0, do8}, 32'h0000FE01);
            check("bp_hold_valid_ready", {30'b0, dv8, ir8}, 32'd2);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        iv8 = 1'b0;
        check("bp_release_valid_ready", {30'b0, dv8, ir8}, 32'd1);
        check("bp_retain_data", {16'h0, do8}, 32'h0000FE01);
        tick();
        check("bp_no_accept", 32'(ir8), 32'd1);

        // Reset in the middle of BUSY
        a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick(); tick(); tick();
        check("mid_busy_state", {30'b0, st8}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(ir8), 32'd1);
        check("mid_rst_valid", 32'(dv8), 32'd0);
        check("mid_rst_dout", {16'h0, do8}, 32'd0);
        run_op(1'b0, 16'd3, 16'd5, 1'b0, 0, prod, lat);
        check("after_rst_product", prod, 32'h0000000F);
        check("after_rst_latency", 32'(lat), 32'd8);

        // Streaming with valid and ready held high
        or8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); iv8 = 1'b1;
        n_res = 0;
        for (int c = 0; c < 75; c++) begin
            acc_now = ir8 && iv8;
            if (acc_now) begin
                exp_q.push_back(ref_mul(1'b0, {8'h0, a8}, {8'h0, b8}, s8));
                acc_cyc.push_back(c);
            end
            if (c == 55) iv8 = 1'b0;
            tick();
            if (acc_now) begin
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            end
            if (dv8) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("stream_product", {16'h0, do8}, e);
                n_res++;
            end
        end
        or8 = 1'b0;
        check("stream_accept_count", 32'(acc_cyc.size()), 32'd6);
        check("stream_result_count", 32'(n_res), 32'(acc_cyc.size()));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("stream_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd10);
        exp_q.delete();

        // Randomised operations with random consumer stalls, both widths
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [15:0] ra, rb;
                bit rs;
                int stall;
                ra = pick_operand(w[0]);
                rb = pick_operand(w[0]);
                rs = 1'($urandom_range(0, 1));
                stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                exp_q.push_back(ref_mul(w[0], ra, rb, rs));
                run_op(w[0], ra, rb, rs, stall, prod, lat);
                e = exp_q.pop_front();
                check(w[0] ? "rand16_product" : "rand8_product", prod, e);
                check(w[0] ? "rand16_latency" : "rand8_latency", 32'(lat), w[0] ? 32'd16 : 32'd8);
                if ($urandom_range(0, 7) == 0) tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
